// File: rtl/sd_reg_pkg.sv
// Shared constants and request-size encoding for the SD host register file.
package sd_reg_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int REG_BYTES = 256;

  // Access size carried on the req bus; REQ_NONE means idle.
  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_BYTE = 2'b01,
    REQ_HALF = 2'b10,
    REQ_WORD = 2'b11
  } req_size_e;

endpackage

// File: rtl/sd_reg_lane_dec.sv
// Turns an access size and byte address into the naturally aligned base
// address and the byte lanes (relative to that base) the access touches.
module sd_reg_lane_dec
  import sd_reg_pkg::*;
(
  input  logic [1:0]        i_req,
  input  logic [ADDR_W-1:0] i_address,
  output logic [ADDR_W-1:0] o_aligned_addr,
  output logic [3:0]        o_lane_en
);

  req_size_e w_size;

  assign w_size = req_size_e'(i_req);

  // Clear the low address bits implied by the size and enable that many lanes.
  always_comb begin
    o_aligned_addr = i_address;
    o_lane_en      = 4'b0000;
    case (w_size)
      REQ_BYTE: begin
        o_aligned_addr = i_address;
        o_lane_en      = 4'b0001;
      end
      REQ_HALF: begin
        o_aligned_addr = {i_address[ADDR_W-1:1], 1'b0};
        o_lane_en      = 4'b0011;
      end
      REQ_WORD: begin
        o_aligned_addr = {i_address[ADDR_W-1:2], 2'b00};
        o_lane_en      = 4'b1111;
      end
      default: begin
        o_aligned_addr = i_address;
        o_lane_en      = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/sd_host_register_set.sv
// 256-byte little-endian register file for the SD host controller with
// 8/16/32-bit bus access and a flat live image for the controller core.
//
// Handshake: an access is taken on any rising edge where req != 00 and ack
// is low. ack is high for exactly the following cycle, during which write
// data is already visible on mem_data_out and read data is on data_out.
// While ack is high a pending req is ignored, so a held req yields one
// access every two cycles. data_out keeps the last read value until the
// next read or reset.
module sd_host_register_set
  import sd_reg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wnr,
  input  logic [1:0]             req,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      data_in,
  output logic [DATA_W-1:0]      data_out,
  output logic                   ack,
  output logic [8*REG_BYTES-1:0] mem_data_out
);

  logic [7:0]        r_mem [REG_BYTES];
  logic              r_ack;
  logic [DATA_W-1:0] r_data_out;

  logic [ADDR_W-1:0] w_ea;
  logic [3:0]        w_lane_en;
  logic              w_accept;
  logic [DATA_W-1:0] w_rd_data;

  sd_reg_lane_dec u_lane_dec (
    .i_req          (req),
    .i_address      (address),
    .o_aligned_addr (w_ea),
    .o_lane_en      (w_lane_en)
  );

  assign w_accept = (req != REQ_NONE) && !r_ack;

  // Gather the enabled lanes starting at the aligned address, zero-extended.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane_en[k]) begin
        w_rd_data[8*k +: 8] = r_mem[w_ea + 8'(k)];
      end
    end
  end

  // Byte storage: clear on reset, otherwise update enabled lanes on a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < REG_BYTES; a++) begin
        r_mem[a] <= 8'h00;
      end
    end else if (w_accept && wnr) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_ea + 8'(k)] <= data_in[8*k +: 8];
        end
      end
    end
  end

  // Completion pulse and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack      <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept && !wnr) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign ack      = r_ack;
  assign data_out = r_data_out;

  // Flatten storage into the live image; byte a sits at [8a+7:8a].
  for (genvar a = 0; a < REG_BYTES; a++) begin : g_image
    assign mem_data_out[8*a +: 8] = r_mem[a];
  end

endmodule

// File: tb/tb_sd_host_register_set.sv
// Directed bench for sd_host_register_set: hand-computed expectations for
// reset, each access size, alignment, held requests and reset collision.
module tb_sd_host_register_set;

  logic        clk;
  logic        reset;
  logic        wnr;
  logic [1:0]  req;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic [2047:0] mem_data_out;

  int n_checks;
  int n_fail;

  sd_host_register_set dut (
    .clk          (clk),
    .reset        (reset),
    .wnr          (wnr),
    .req          (req),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .ack          (ack),
    .mem_data_out (mem_data_out)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_byte(input int a);
    return mem_data_out[8*a +: 8];
  endfunction

  // Driver: one access, sampled at the ack cycle and the cycle after.
  task automatic do_access(input logic w, input logic [1:0] sz,
                           input logic [7:0] a, input logic [31:0] d,
                           output logic ack_hit, output logic [31:0] dout,
                           output logic ack_after);
    @(negedge clk);
    wnr = w; req = sz; address = a; data_in = d;
    @(negedge clk);
    ack_hit = ack; dout = data_out; req = 2'b00;
    @(negedge clk);
    ack_after = ack;
  endtask

  task automatic test_reset();
    int nz;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nz = 0;
    for (int a = 0; a < 256; a++) if (mem_byte(a) !== 8'h00) nz++;
    n_checks++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL reset_mem: %0d nonzero bytes, required 0", nz);
    end
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: got %b required 0", ack);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h required 00000000", data_out);
    end
  endtask

  task automatic test_word();
    logic a1, a0; logic [31:0] d;
    // Write inline so the image can be sampled in the ack cycle itself.
    @(negedge clk);
    wnr = 1'b1; req = 2'b11; address = 8'h04; data_in = 32'hDEADBEEF;
    @(negedge clk);
    req = 2'b00;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL word_wr_ack: got %b required 1", ack);
    end
    n_checks++;
    if (mem_data_out[63:32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_wr_image: got %h required deadbeef", mem_data_out[63:32]);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL word_wr_data_out_unchanged: got %h required 00000000", data_out);
    end
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL word_wr_ack_drop: got %b required 0", ack);
    end
    do_access(1'b0, 2'b11, 8'h04, 32'h0, a1, d, a0);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_rd: ack %b data %h required ack 1 data deadbeef", a1, d);
    end
  endtask

  task automatic test_byte();
    logic a1, a0; logic [31:0] d;
    do_access(1'b1, 2'b01, 8'h07, 32'hFFFF_FFA5, a1, d, a0);
    n_checks++;
    if (a1 !== 1'b1 || a0 !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_wr_ack: got %b%b required 10", a1, a0);
    end
    do_access(1'b0, 2'b11, 8'h04, 32'h0, a1, d, a0);
    n_checks++;
    if (d !== 32'hA5ADBEEF) begin
      n_fail++;
      $display("FAIL byte_wr_word_rd: got %h required a5adbeef", d);
    end
    do_access(1'b0, 2'b01, 8'h05, 32'h0, a1, d, a0);
    n_checks++;
    if (d !== 32'h000000BE) begin
      n_fail++;
      $display("FAIL byte_rd_05: got %h required 000000be", d);
    end
    do_access(1'b0, 2'b10, 8'h05, 32'h0, a1, d, a0);
    n_checks++;
    if (d !== 32'h0000BEEF) begin
      n_fail++;
      $display("FAIL half_rd_05_aligned: got %h required 0000beef", d);
    end
  endtask

  task automatic test_half_misaligned();
    logic a1, a0; logic [31:0] d;
    do_access(1'b1, 2'b10, 8'h0B, 32'hFFFF_1234, a1, d, a0);
    n_checks++;
    if (mem_data_out[95:80] !== 16'h1234) begin
      n_fail++;
      $display("FAIL half_wr_image: got %h required 1234", mem_data_out[95:80]);
    end
    n_checks++;
    if (mem_byte(11) !== 8'h12) begin
      n_fail++;
      $display("FAIL half_wr_byte0b: got %h required 12", mem_byte(11));
    end
    n_checks++;
    if (mem_byte(9) !== 8'h00 || mem_byte(12) !== 8'h00) begin
      n_fail++;
      $display("FAIL half_wr_neighbours: got %h %h required 00 00", mem_byte(9), mem_byte(12));
    end
    do_access(1'b0, 2'b11, 8'h0A, 32'h0, a1, d, a0);
    n_checks++;
    if (d !== 32'h12340000) begin
      n_fail++;
      $display("FAIL word_rd_0a_aligned: got %h required 12340000", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [2047:0] exp_img;
    logic [3:0] ack_seq;
    int ndiff, first;
    @(negedge clk);
    wnr = 1'b1; req = 2'b11; address = 8'hFC; data_in = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ack_seq[3-c] = ack;
    end
    req = 2'b00;
    n_checks++;
    if (ack_seq !== 4'b1010) begin
      n_fail++;
      $display("FAIL held_req_ack_seq: got %b required 1010", ack_seq);
    end
    n_checks++;
    if (mem_data_out[2047:2016] !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL held_req_top_word: got %h required cafef00d", mem_data_out[2047:2016]);
    end
    exp_img = '0;
    exp_img[8*4  +: 32] = 32'hA5ADBEEF;
    exp_img[8*10 +: 16] = 16'h1234;
    exp_img[8*252 +: 32] = 32'hCAFEF00D;
    ndiff = 0; first = -1;
    for (int a = 0; a < 256; a++) begin
      if (mem_byte(a) !== exp_img[8*a +: 8]) begin
        ndiff++;
        if (first < 0) first = a;
      end
    end
    n_checks++;
    if (ndiff != 0) begin
      n_fail++;
      $display("FAIL held_req_image: %0d bytes differ, first at %0d, required 0 differing", ndiff, first);
    end
    n_checks++;
    if (data_out !== 32'h12340000) begin
      n_fail++;
      $display("FAIL held_req_data_out_kept: got %h required 12340000", data_out);
    end
  endtask

  task automatic test_reset_collision();
    @(negedge clk);
    reset = 1'b1; wnr = 1'b1; req = 2'b11; address = 8'h00; data_in = 32'h11223344;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_collide_ack: got %b required 0", ack);
    end
    n_checks++;
    if (mem_data_out[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_collide_bytes: got %h required 00000000", mem_data_out[31:0]);
    end
    n_checks++;
    if (mem_data_out[2047:2016] !== 32'h0 || data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_collide_clear: top %h data_out %h required 0 0",
               mem_data_out[2047:2016], data_out);
    end
    reset = 1'b0; req = 2'b00;
    @(negedge clk);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_ack: got %b required 0", ack);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; wnr = 1'b0; req = 2'b00; address = 8'h00; data_in = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half_misaligned();
    test_back_to_back();
    test_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
